// File: rtl/dht_uart_report_if.sv
// dht_uart_report_if: sensor frame input and TX FIFO write port of the report stage
interface dht_uart_report_if;
  logic [39:0] i_data;
  logic        i_done;
  logic        i_full;
  logic        o_push;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_drop;
  modport master (input i_data, i_done, i_full, output o_push, o_tx_data, o_busy, o_drop);
  modport slave (output i_data, i_done, i_full, input o_push, o_tx_data, o_busy, o_drop);
endinterface

// File: rtl/dht_uart_report.sv
// dht_uart_report: converts a DHT11 frame to an 11-byte "Hnnn Tnnn\r\n" line for the TX FIFO
module dht_uart_report #(
  parameter logic [7:0] HUM_CHAR = 8'h48,
  parameter logic [7:0] TMP_CHAR = 8'h54,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input logic clk,
  input logic rst,
  dht_uart_report_if.master bus
);
  typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;
  state_t state, state_nx;
  logic [19:0] hsr, tsr;
  logic [2:0] bit_cnt;
  logic [3:0] idx;
  logic [7:0] cur_byte;
  logic busy, take, send;
  logic unused;
  assign unused = ^{bus.i_data[31:24], bus.i_data[15:0]};
  // busy covers the cycle of the final push, so a done arriving on the return to IDLE is dropped
  assign busy = (state != IDLE) || bus.o_push;
  assign take = bus.i_done && !busy;
  assign send = (state == SEND) && !bus.i_full && (idx <= 4'd10);
  assign bus.o_busy = busy;
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int k = 0; k < 3; k++)
      if (a[8+4*k +: 4] >= 4'd5) a[8+4*k +: 4] = a[8+4*k +: 4] + 4'd3;
    return a << 1;
  endfunction
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? CONVERT : IDLE;
      CONVERT: state_nx = (bit_cnt == 3'd7) ? SEND : CONVERT;
      SEND:    state_nx = ((idx > 4'd10) || (send && idx == 4'd10)) ? IDLE : SEND;
      default: state_nx = IDLE;
    endcase
  end
  // byte selected by the current line index
  always_comb begin
    cur_byte = 8'h0A;
    case (idx)
      4'd0: cur_byte = HUM_CHAR;
      4'd1: cur_byte = {4'h3, hsr[19:16]};
      4'd2: cur_byte = {4'h3, hsr[15:12]};
      4'd3: cur_byte = {4'h3, hsr[11:8]};
      4'd4: cur_byte = SEP_CHAR;
      4'd5: cur_byte = TMP_CHAR;
      4'd6: cur_byte = {4'h3, tsr[19:16]};
      4'd7: cur_byte = {4'h3, tsr[15:12]};
      4'd8: cur_byte = {4'h3, tsr[11:8]};
      4'd9: cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end
  // capture, double-dabble conversion, registered FIFO write and drop pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hsr <= '0;
      tsr <= '0;
      bit_cnt <= '0;
      idx <= '0;
      bus.o_push <= 1'b0;
      bus.o_tx_data <= '0;
      bus.o_drop <= 1'b0;
    end else begin
      bus.o_drop <= bus.i_done && busy;
      bus.o_push <= send;
      if (take) begin
        hsr <= {12'd0, bus.i_data[39:32]};
        tsr <= {12'd0, bus.i_data[23:16]};
        bit_cnt <= '0;
      end
      if (state == CONVERT) begin
        hsr <= dabble(hsr);
        tsr <= dabble(tsr);
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) idx <= '0;
      end
      if (send) begin
        bus.o_tx_data <= cur_byte;
        idx <= idx + 4'd1;
      end
    end
endmodule

// File: doc/dht_uart_report.md
Name: dht_uart_report

Overview:
- Downstream consumer of the DHT11 sensor stage.
- On each completed sensor read, captures the 40-bit frame and converts the humidity and temperature integer bytes to 3-digit decimal ASCII.
- Pushes a fixed 11-byte text line into the UART TX FIFO, e.g. "H045 T023" CR LF.
- Sits between the DHT11 stage (data, done) and the UART TX FIFO write port.

Parameters:
- HUM_CHAR, 8'h48 ("H"): first byte of the humidity field.
- TMP_CHAR, 8'h54 ("T"): first byte of the temperature field.
- SEP_CHAR, 8'h20 (space): byte between the two fields.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- i_data  input  40  sensor frame. [39:32] humidity integer, [31:24] humidity decimal, [23:16] temperature integer, [15:8] temperature decimal, [7:0] checksum.
- i_done  input  1  single-cycle pulse; i_data is valid in the same cycle.
- i_full  input  1  TX FIFO full flag.
- o_push  output  1  TX FIFO write strobe, 1 cycle per byte.
- o_tx_data  output  8  byte to write; valid while o_push=1.
- o_busy  output  1  high while a report is being converted or sent.
- o_drop  output  1  1-cycle pulse when an i_done arrives while busy.

Behaviour:
- Reset (rst=0, async): state IDLE; o_push=0, o_tx_data=0, o_busy=0, o_drop=0; all internal registers cleared.
- Reset asserted mid-report aborts it immediately. No further bytes are pushed; a partial line may remain in the FIFO.
- States: IDLE, CONVERT, SEND.
- IDLE:
  - On i_done=1: latch hum=i_data[39:32] and tmp=i_data[23:16]; clear the bit counter; go to CONVERT.
  - o_busy=1 from the next cycle.
  - Decimal bytes and checksum are ignored; checksum validation belongs to the sensor stage.
- CONVERT:
  - Shift-add-3 (double-dabble) binary-to-BCD on hum and tmp in parallel, one bit per cycle.
  - Exactly 8 cycles, giving 3 BCD digits each. 255 maps to 2,5,5.
  - After the 8th cycle: byte index = 0; go to SEND.
- SEND, byte order, index 0..10:
  - 0: HUM_CHAR
  - 1-3: hum hundreds, tens, units, each as 8'h30 + digit
  - 4: SEP_CHAR
  - 5: TMP_CHAR
  - 6-8: tmp hundreds, tens, units
  - 9: 8'h0D
  - 10: 8'h0A
- SEND handshake:
  - In any cycle with i_full=0: o_push=1, o_tx_data=byte[index], index increments.
  - In any cycle with i_full=1: o_push=0, index holds, o_tx_data holds.
  - o_push and o_tx_data are registered. Each decision is made on the i_full sampled that cycle, and the strobe appears on the following cycle.
  - No byte is ever pushed twice or skipped.
  - Continuous push possible: 11 consecutive cycles with i_full=0 give 11 back-to-back pushes.
- End of line: after the push of index 10, return to IDLE; o_busy drops on the cycle after the last o_push.
- Latency with FIFO never full:
  - i_done at cycle 0.
  - First o_push at cycle 10 (1 latch + 8 convert + 1 register).
  - Last o_push at cycle 20.
  - o_busy low at cycle 21.
- Overrun: i_done while o_busy=1 is dropped. The latched values are unchanged and o_drop pulses for 1 cycle.
- Same-cycle case: i_done in the same cycle as the transition back to IDLE counts as busy and is dropped.
- Width rules:
  - BCD shift register is 12 bits (digits) + 8 bits (binary) per channel.
  - Add-3 applies to any nibble >= 5 before each shift.
  - The byte index is a 4-bit counter. Values 11..15 are unreachable and map to IDLE.

Test Plan:
- Basic report: i_data=40'h2D00_1700_44, one i_done pulse, i_full=0.
  - Bytes pushed in order: 48 30 34 35 20 54 30 32 33 0D 0A.
  - First push 10 cycles after i_done; o_busy low at cycle 21.
- Range extremes: hum=8'hFF, tmp=8'h00.
  - Digits: "H255 T000" CR LF.
  - Then hum=100, tmp=9 gives "H100 T009" CR LF.
- Backpressure: hold i_full=1 for 5 cycles starting at byte index 3, then release.
  - No o_push during the hold.
  - The sequence resumes with byte 35 and no duplicate or missing byte.
  - Total 11 pushes.
- Overrun: second i_done 4 cycles after the first.
  - o_drop pulses once.
  - Output line reflects the first frame only.
  - A third i_done after o_busy falls produces a full second line.
- Reset mid-SEND: drive rst=0 after 5 pushes.
  - o_push, o_busy, o_tx_data go 0 immediately (asynchronous).
  - After release, a new i_done produces a complete 11-byte line.
